// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder.
// Holds the write bit position inside the request opcode, the access size
// encoding and the responder's state encoding.
package mem_pkg;

    // Bit of req_op that selects a store; bits [1:0] hold the access size.
    localparam int MEM_OP_WRITE = 2;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } resp_state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response handshake bundle between the core and the memory responder.
// Signals:
//   req_valid / req_ready       request handshake
//   req_op, req_unsigned        access type and load extension
//   req_addr, req_wdata         byte address and right-justified store data
//   rsp_valid / rsp_ready       response handshake
//   rsp_data, rsp_fault         load result and fault flag
// The master modport belongs to the requester and the slave modport to the responder.
interface mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_fault;

    modport master (
        output req_valid, req_op, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_fault
    );

    modport slave (
        input  req_valid, req_op, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_fault
    );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for sub-word accesses.
// Ports:
//   lane        in   byte offset inside the word (addr[1:0])
//   size        in   access size
//   is_unsigned in   zero-extend (1) or sign-extend (0) sub-word loads
//   wdata       in   right-justified store data
//   rdata       in   full RAM word being read
//   byte_en     out  lanes written by a store
//   wdata_lanes out  store data replicated so every enabled lane sees its byte
//   rdata_ext   out  load result shifted down and extended
//   misalign    out  half or word access that is not naturally aligned
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  lane,
    input  mem_size_t   size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic [31:0] rdata_shifted;

    assign rdata_shifted = rdata >> {lane, 3'b000};

    // Store data is replicated across lanes, so the byte enable alone picks
    // which copy lands in the RAM. Illegal sizes enable nothing.
    always_comb begin
        byte_en     = 4'b0000;
        wdata_lanes = 32'h0;
        rdata_ext   = 32'h0;
        misalign    = 1'b0;
        case (size)
            SZ_BYTE: begin
                byte_en     = 4'b0001 << lane;
                wdata_lanes = {4{wdata[7:0]}};
                rdata_ext   = is_unsigned ? {24'h0, rdata_shifted[7:0]}
                                          : {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            end
            SZ_HALF: begin
                misalign    = lane[0];
                byte_en     = 4'b0011 << lane;
                wdata_lanes = {2{wdata[15:0]}};
                rdata_ext   = is_unsigned ? {16'h0, rdata_shifted[15:0]}
                                          : {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            end
            SZ_WORD: begin
                misalign    = |lane;
                byte_en     = 4'b1111;
                wdata_lanes = wdata;
                rdata_ext   = rdata;
            end
            default: begin
                byte_en = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one load/store/fetch at a time over a
// valid/ready handshake, waits WAIT_CYCLES extra cycles, performs the access
// on a word-organised RAM and returns load data or a fault.
// Ports:
//   clk    in   clock, all state changes on posedge
//   reset  in   synchronous active-high reset (RAM contents are kept)
//   bus    slave side of mem_responder_if
module mem_responder
    import mem_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           reset,
    mem_responder_if.slave bus
);

    localparam int          DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [33:0] SPAN  = 34'd4 << ADDR_WIDTH;
    localparam int          CW    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_BUSY = BUSY;
    localparam logic [1:0] ST_RESP = RESP;

    logic [1:0]            state;
    logic [CW-1:0]         count;
    logic [2:0]            op_q;
    logic                  unsigned_q;
    logic [31:0]           addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rsp_data_q;
    logic                  rsp_fault_q;

    logic [31:0]           ram [DEPTH];

    logic [33:0]           offset;
    logic                  out_of_range;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [31:0]           ram_word;
    logic [3:0]            byte_en;
    logic [31:0]           wdata_lanes;
    logic [31:0]           rdata_ext;
    logic                  misalign;
    logic                  fault;
    logic                  is_write;
    logic                  access;

    // Range check is done on 34 bits so addresses near the top of the 32-bit
    // space cannot wrap back into the RAM window.
    assign offset       = {2'b00, addr_q} - {2'b00, BASE_ADDR};
    assign out_of_range = (addr_q < BASE_ADDR) || (offset >= SPAN);
    assign word_idx     = offset[ADDR_WIDTH+1:2];
    assign ram_word     = ram[word_idx];
    assign is_write     = op_q[MEM_OP_WRITE];
    assign fault        = (op_q[1:0] == SZ_ILLEGAL) || misalign || out_of_range;
    assign access       = (state == ST_BUSY) && (count == '0);

    mem_lane_align u_align (
        .lane        (addr_q[1:0]),
        .size        (mem_size_t'(op_q[1:0])),
        .is_unsigned (unsigned_q),
        .wdata       (wdata_q),
        .rdata       (ram_word),
        .byte_en     (byte_en),
        .wdata_lanes (wdata_lanes),
        .rdata_ext   (rdata_ext),
        .misalign    (misalign)
    );

    // Request intake, wait countdown and response hand-off. The access itself
    // happens on the edge that leaves BUSY, so a reset before then drops it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            count       <= '0;
            op_q        <= 3'b000;
            unsigned_q  <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            rsp_data_q  <= 32'h0;
            rsp_fault_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        op_q       <= bus.req_op;
                        unsigned_q <= bus.req_unsigned;
                        addr_q     <= bus.req_addr;
                        wdata_q    <= bus.req_wdata;
                        count      <= CW'(WAIT_CYCLES);
                        state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (count == '0) begin
                        rsp_data_q  <= (fault || is_write) ? 32'h0 : rdata_ext;
                        rsp_fault_q <= fault;
                        state       <= ST_RESP;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // RAM write port: byte-lane masked, never reset, gated off by reset so a
    // store caught by reset mid-flight leaves memory untouched.
    always_ff @(posedge clk) begin
        if (!reset && access && is_write && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    ram[word_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
                end
            end
        end
    end

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.rsp_valid = (state == ST_RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomised self-checking bench for mem_responder against a byte-array
// reference model of the RAM window.
module tb_mem_responder;

    localparam int          AW   = 8;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          W    = 2;
    localparam longint      SPAN = 4 * (2 ** AW);

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    logic [7:0] model_mem [SPAN];

    mem_responder_if bus ();

    mem_responder #(
        .ADDR_WIDTH  (AW),
        .BASE_ADDR   (BASE),
        .WAIT_CYCLES (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Reference: access rules applied directly to a byte array.
    task automatic modelAccess(input logic [2:0] op, input logic uns, input logic [31:0] addr,
                               input logic [31:0] wdata, output logic [31:0] exp_data,
                               output logic exp_fault);
        longint off;
        longint val;
        int     size;
        int     nb;
        off       = longint'(addr) - longint'(BASE);
        size      = int'(op[1:0]);
        exp_fault = 1'b0;
        exp_data  = 32'h0;
        if (size == 3) exp_fault = 1'b1;
        else if (off < 0 || off >= SPAN) exp_fault = 1'b1;
        else if ((longint'(addr) % (longint'(1) << size)) != 0) exp_fault = 1'b1;
        if (!exp_fault) begin
            nb = 1 << size;
            if (op[2]) begin
                for (int i = 0; i < nb; i++) model_mem[int'(off) + i] = wdata[8*i +: 8];
            end else begin
                val = 0;
                for (int i = 0; i < nb; i++) val = val | (longint'(model_mem[int'(off) + i]) << (8 * i));
                if (!uns && nb < 4 && val[8*nb-1]) val = val - (longint'(1) << (8 * nb));
                exp_data = val[31:0];
            end
        end
    endtask

    // Drives a request, waits for acceptance, scrambles req_* and measures
    // the number of edges from acceptance to rsp_valid.
    task automatic sendRequest(input logic [2:0] op, input logic uns, input logic [31:0] addr,
                               input logic [31:0] wdata, output int latency);
        int n;
        bus.req_op       = op;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_valid    = 1'b1;
        bus.rsp_ready    = 1'b0;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.req_ready) checkOutput("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.req_valid    = 1'b0;
        bus.req_op       = 3'($urandom);
        bus.req_unsigned = 1'($urandom);
        bus.req_addr     = $urandom;
        bus.req_wdata    = $urandom;
        latency = 0;
        while (!bus.rsp_valid && latency < 100) begin
            @(posedge clk); #1;
            latency++;
        end
    endtask

    // Holds rsp_ready low for 'stall' cycles checking the response is stable,
    // then completes the handshake.
    task automatic finishResponse(input int stall, output logic [31:0] data, output logic fault);
        data  = bus.rsp_data;
        fault = bus.rsp_fault;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            checkOutput("stall_valid", 32'(bus.rsp_valid), 32'd1);
            checkOutput("stall_data", bus.rsp_data, data);
            checkOutput("stall_fault", 32'(bus.rsp_fault), 32'(fault));
            checkOutput("stall_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
        checkOutput("post_hs_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("post_hs_ready", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic applyStimulus(input string tag, input logic [2:0] op, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata, input int stall,
                                 output logic [31:0] data, output logic fault);
        int          lat;
        logic [31:0] exp_data;
        logic        exp_fault;
        sendRequest(op, uns, addr, wdata, lat);
        checkOutput({tag, "_latency"}, 32'(lat), 32'(W + 1));
        finishResponse(stall, data, fault);
        modelAccess(op, uns, addr, wdata, exp_data, exp_fault);
        checkOutput({tag, "_data"}, data, exp_data);
        checkOutput({tag, "_fault"}, 32'(fault), 32'(exp_fault));
    endtask

    initial begin
        logic [31:0] d;
        logic        f;
        int          lat;
        logic [31:0] a;
        checks   = 0;
        failures = 0;
        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_op     = 3'b000;
        bus.req_unsigned = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.rsp_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rst_rsp_data", bus.rsp_data, 32'h0);
        checkOutput("rst_rsp_fault", 32'(bus.rsp_fault), 32'd0);

        // Fill the whole RAM so every later load has a known value.
        for (int w = 0; w < 2 ** AW; w++)
            applyStimulus("init", 3'b110, 1'b0, BASE + 32'(4 * w), $urandom, 0, d, f);

        applyStimulus("st_word", 3'b110, 1'b0, BASE + 32'h100, 32'hDEADBEEF, 0, d, f);
        applyStimulus("ld_word", 3'b010, 1'b0, BASE + 32'h100, 32'h0, 0, d, f);
        checkOutput("deadbeef", d, 32'hDEADBEEF);

        applyStimulus("st_base", 3'b110, 1'b0, BASE + 32'h100, 32'h11223344, 0, d, f);
        applyStimulus("st_byte", 3'b100, 1'b0, BASE + 32'h103, 32'h000000AB, 1, d, f);
        applyStimulus("ld_merge", 3'b010, 1'b1, BASE + 32'h100, 32'h0, 0, d, f);
        checkOutput("byte_merge", d, 32'hAB223344);
        applyStimulus("ld_sbyte", 3'b000, 1'b0, BASE + 32'h103, 32'h0, 0, d, f);
        checkOutput("sbyte", d, 32'hFFFFFFAB);
        applyStimulus("ld_ubyte", 3'b000, 1'b1, BASE + 32'h103, 32'h0, 0, d, f);
        checkOutput("ubyte", d, 32'h000000AB);

        applyStimulus("mis_half", 3'b001, 1'b0, BASE + 32'h101, 32'h0, 0, d, f);
        checkOutput("mis_half_flag", 32'(f), 32'd1);
        applyStimulus("mis_word", 3'b110, 1'b0, BASE + 32'h102, 32'hFFFFFFFF, 0, d, f);
        checkOutput("mis_word_flag", 32'(f), 32'd1);
        applyStimulus("illegal", 3'b011, 1'b0, BASE + 32'h100, 32'h0, 0, d, f);
        checkOutput("illegal_flag", 32'(f), 32'd1);
        checkOutput("illegal_data", d, 32'h0);
        applyStimulus("ld_after_f", 3'b010, 1'b0, BASE + 32'h100, 32'h0, 0, d, f);
        checkOutput("unchanged", d, 32'hAB223344);

        applyStimulus("oor_low", 3'b110, 1'b0, BASE - 32'd4, 32'h12345678, 0, d, f);
        checkOutput("oor_low_flag", 32'(f), 32'd1);
        applyStimulus("oor_high", 3'b110, 1'b0, BASE + 32'(SPAN), 32'h12345678, 0, d, f);
        checkOutput("oor_high_flag", 32'(f), 32'd1);
        applyStimulus("oor_top", 3'b110, 1'b0, 32'hFFFFFFFC, 32'h12345678, 0, d, f);
        checkOutput("oor_top_flag", 32'(f), 32'd1);
        applyStimulus("edge_lo", 3'b010, 1'b0, BASE, 32'h0, 0, d, f);
        applyStimulus("edge_hi", 3'b010, 1'b0, BASE + 32'(SPAN) - 32'd4, 32'h0, 0, d, f);

        // Stall: a second request offered while the response waits must be ignored.
        sendRequest(3'b010, 1'b0, BASE + 32'h100, 32'h0, lat);
        checkOutput("stall_latency", 32'(lat), 32'(W + 1));
        bus.req_valid = 1'b1;
        bus.req_op    = 3'b110;
        bus.req_addr  = BASE + 32'h200;
        bus.req_wdata = 32'hCAFEF00D;
        finishResponse(5, d, f);
        checkOutput("stall_rsp", d, 32'hAB223344);
        for (int i = 0; i < W + 3; i++) begin
            @(posedge clk); #1;
            checkOutput("no_ghost", 32'(bus.rsp_valid), 32'd0);
        end
        applyStimulus("intruder", 3'b010, 1'b0, BASE + 32'h200, 32'h0, 0, d, f);

        // Reset one cycle after accepting a store: store must be dropped.
        applyStimulus("pre_rst", 3'b010, 1'b0, BASE, 32'h0, 0, d, f);
        a = d;
        bus.req_op    = 3'b110;
        bus.req_addr  = BASE;
        bus.req_wdata = (a == 32'h55) ? 32'h66 : 32'h55;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("mid_rst_ready", 32'(bus.req_ready), 32'd1);
        repeat (W + 2) @(posedge clk);
        #1 checkOutput("mid_rst_quiet", 32'(bus.rsp_valid), 32'd0);
        applyStimulus("post_rst", 3'b010, 1'b0, BASE, 32'h0, 0, d, f);
        checkOutput("post_rst_old", d, a);

        for (int t = 0; t < 150; t++) begin
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = BASE + 32'($urandom_range(0, int'(SPAN) - 1));
            applyStimulus("rand", 3'($urandom_range(0, 7)), 1'($urandom), a, $urandom,
                          int'($urandom_range(0, 2)), d, f);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
